// File: rtl/ex_ma_pipe_reg_if.sv
// rtl/ex_ma_pipe_reg_if.sv - valid/ready bus carrying one packed EX/MA entry
interface ex_ma_pipe_reg_if #(
  parameter int BUS_W = 79
);
  logic [BUS_W-1:0] bus;
  logic             valid;
  logic             ready;

  modport master (output bus, output valid, input ready);
  modport slave  (input bus, input valid, output ready);
endinterface

// File: rtl/ex_ma_pipe_reg.sv
// rtl/ex_ma_pipe_reg.sv - two-entry (main + skid) EX/MA pipeline register with flush and stall counter
module ex_ma_pipe_reg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  ex_ma_pipe_reg_if.slave       ex_if,
  ex_ma_pipe_reg_if.master      ma_if,
  output logic [1:0]            occupancy_o,
  output logic [CNT_W-1:0]      stall_count_o
);
  localparam int BUS_W = ADDR_W + DATA_W + REG_W + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BUS_W-1:0]   main_q, main_d;
  logic [BUS_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q;
  logic               ex_ready;
  logic               ma_valid;
  logic               push;
  logic               pop;

  // Ready depends only on registered state so EX never sees a path from ma_ready.
  assign ex_ready = !rst_i && (state_q != TWO);
  assign ma_valid = (state_q != EMPTY);
  assign push     = ex_if.valid && ex_ready;
  assign pop      = ma_valid && ma_if.ready;

  assign ex_if.ready   = ex_ready;
  assign ma_if.valid   = ma_valid;
  assign ma_if.bus     = ma_valid ? main_q : '0;
  assign occupancy_o   = state_q;
  assign stall_count_o = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = ex_if.bus;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
          skid_d  = ex_if.bus;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          main_d  = ex_if.bus;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Stale main/skid contents are harmless: ma_bus is masked while EMPTY.
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      if (ma_valid && !ma_if.ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ex_ma_pipe_reg.sv
// tb/tb_ex_ma_pipe_reg.sv - scoreboard bench for ex_ma_pipe_reg (two instances: CNT_W=16 and CNT_W=4)
module tb_ex_ma_pipe_reg;
  localparam int BUS_W = 79;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_v;
  logic             ex_valid_v;
  logic             ma_ready_v;
  logic [BUS_W-1:0] ex_bus_v;

  always #5 clk = ~clk;

  ex_ma_pipe_reg_if #(.BUS_W(BUS_W)) ex_a ();
  ex_ma_pipe_reg_if #(.BUS_W(BUS_W)) ma_a ();
  ex_ma_pipe_reg_if #(.BUS_W(BUS_W)) ex_b ();
  ex_ma_pipe_reg_if #(.BUS_W(BUS_W)) ma_b ();

  assign ex_a.bus   = ex_bus_v;
  assign ex_a.valid = ex_valid_v;
  assign ma_a.ready = ma_ready_v;
  assign ex_b.bus   = ex_bus_v;
  assign ex_b.valid = ex_valid_v;
  assign ma_b.ready = ma_ready_v;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  ex_ma_pipe_reg #(.CNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_v),
    .ex_if(ex_a), .ma_if(ma_a),
    .occupancy_o(occ_a), .stall_count_o(stall_a)
  );

  ex_ma_pipe_reg #(.CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_v),
    .ex_if(ex_b), .ma_if(ma_b),
    .occupancy_o(occ_b), .stall_count_o(stall_b)
  );

  // Reference model: an ordered queue of accepted entries plus an unbounded stall tally.
  logic [BUS_W-1:0] exp_q[$];
  int               stall_m;
  int               checks;
  int               errors;
  int               delivered;
  bit               chk_en;
  int               n;
  logic [BUS_W-1:0] front;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n     = exp_q.size();
      front = (n > 0) ? exp_q[0] : '0;
      chk("ex_ready_a", 128'(ex_a.ready), 128'(!rst && n < 2));
      chk("ex_ready_b", 128'(ex_b.ready), 128'(!rst && n < 2));
      chk("ma_valid_a", 128'(ma_a.valid), 128'(n > 0));
      chk("ma_valid_b", 128'(ma_b.valid), 128'(n > 0));
      chk("ma_bus_a", 128'(ma_a.bus), 128'(front));
      chk("ma_bus_b", 128'(ma_b.bus), 128'(front));
      chk("occupancy_a", 128'(occ_a), 128'(n));
      chk("occupancy_b", 128'(occ_b), 128'(n));
      chk("stall_a", 128'(stall_a), 128'((stall_m > 65535) ? 65535 : stall_m));
      chk("stall_b", 128'(stall_b), 128'((stall_m > 15) ? 15 : stall_m));
      if (rst) begin
        exp_q.delete();
        stall_m = 0;
      end else begin
        if (n > 0 && !ma_ready_v) stall_m++;
        if (n > 0 && ma_ready_v) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (flush_v) exp_q.delete();
        else if (ex_valid_v && n < 2) exp_q.push_back(ex_bus_v);
      end
    end
  end

  task automatic drive(input bit r, input bit v, input logic [BUS_W-1:0] b, input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    rst        = r;
    ex_valid_v = v;
    ex_bus_v   = b;
    ma_ready_v = rdy;
    flush_v    = fl;
  endtask

  function automatic logic [BUS_W-1:0] mk(input int i);
    return {1'b1, 1'b0, 1'b0, 4'd6, 64'(5 + i), 8'(8'h11 + i)};
  endfunction

  function automatic logic [BUS_W-1:0] rnd_bus();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[BUS_W-1:0];
  endfunction

  initial begin
    checks = 0; errors = 0; delivered = 0; stall_m = 0; chk_en = 1'b0;
    rst = 1'b1; ex_valid_v = 1'b0; ex_bus_v = '0; ma_ready_v = 1'b1; flush_v = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    drive(1, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);
    // back-to-back with ma_ready high
    for (int i = 0; i < 4; i++) drive(0, 1, mk(i), 1, 0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);
    // fill both entries, hold C until space appears
    drive(0, 1, mk(10), 0, 0);
    drive(0, 1, mk(11), 0, 0);
    repeat (3) drive(0, 1, mk(12), 0, 0);
    drive(0, 1, mk(12), 1, 0);
    drive(0, 1, mk(12), 1, 0);
    repeat (3) drive(0, 0, '0, 1, 0);
    // flush while TWO with a pending input
    drive(0, 1, mk(20), 0, 0);
    drive(0, 1, mk(21), 0, 0);
    drive(0, 1, mk(22), 0, 1);
    drive(0, 0, '0, 0, 0);
    drive(0, 0, '0, 1, 0);
    // one entry stalled long enough to saturate the 4-bit counter
    drive(0, 1, mk(30), 0, 0);
    repeat (20) drive(0, 0, '0, 0, 0);
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 6),
            rnd_bus(),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 32) == 0));
    end
    repeat (4) drive(0, 0, '0, 1, 0);
    @(posedge clk);
    #1;
    chk("delivered_some", 128'(delivered > 100), 128'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
